dmem_access_ctrl: RTL

- Sequences and arbitrates the single-port data memory between two requesters: the pipeline memory stage (single-word ld/st) and the FFT engine (fixed-length bursts from a base address).
- Sits between the memory stage, the FFT engine and the data memory macro.
- Generates the pipeline stall, returns load data, and honours the branch flush.
- Round-robin fairness: after a burst completes, a pending pipeline request is served before the next burst.

---
 rtl/dmem_access_ctrl_if.sv | 56 +++++
 rtl/dmem_access_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - bundle of the pipeline, FFT and memory-macro signals of dmem_access_ctrl
//
// Groups every handshake/bus signal of the data-memory access controller.
//   master : controller side (drives stall/response/grant/memory outputs)
//   slave  : environment side (pipeline, FFT engine and memory macro)
// Signal groups:
//   pipe_* : memory-stage single-word load/store requests and load response
//   fft_*  : FFT engine burst request, grant, beat strobe and read response
//   mem_*  : single-port data memory macro (1-cycle registered read latency)
interface dmem_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              pipe_ld;
    logic              pipe_st;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_flush;
    logic              pipe_stall;
    logic [DATA_W-1:0] pipe_rdata;
    logic              pipe_rvalid;

    logic              fft_req;
    logic              fft_we;
    logic [ADDR_W-1:0] fft_base;
    logic [DATA_W-1:0] fft_wdata;
    logic              fft_gnt;
    logic              fft_beat;
    logic [DATA_W-1:0] fft_rdata;
    logic              fft_rvalid;
    logic              fft_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  pipe_ld, pipe_st, pipe_addr, pipe_wdata, pipe_flush,
        output pipe_stall, pipe_rdata, pipe_rvalid,
        input  fft_req, fft_we, fft_base, fft_wdata,
        output fft_gnt, fft_beat, fft_rdata, fft_rvalid, fft_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output pipe_ld, pipe_st, pipe_addr, pipe_wdata, pipe_flush,
        input  pipe_stall, pipe_rdata, pipe_rvalid,
        output fft_req, fft_we, fft_base, fft_wdata,
        input  fft_gnt, fft_beat, fft_rdata, fft_rvalid, fft_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - single-port data memory sequencer/arbiter for pipeline ld/st and FFT bursts
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : dmem_access_ctrl_if.master
//           pipe_* in : ld/st request, address, store data, branch flush
//           pipe_* out: pipe_stall (combinational), pipe_rdata/pipe_rvalid (registered)
//           fft_*  in : burst request, direction, base address, per-beat write data
//           fft_*  out: fft_gnt, fft_beat, fft_rvalid, fft_done (registered), fft_rdata
//           mem_*     : memory macro enable/write/address/data, read data one cycle later
module dmem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int FFT_LEN = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_access_ctrl_if.master    bus
);

    localparam int BEAT_W = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        P_RD,
        P_RESP,
        F_BURST,
        F_DRAIN
    } state_t;

    localparam logic OWNER_PIPE = 1'b0;
    localparam logic OWNER_FFT  = 1'b1;

    state_t              state_q,      state_d;
    logic                last_owner_q, last_owner_d;
    logic [BEAT_W-1:0]   beat_q,       beat_d;
    logic                flushed_q,    flushed_d;
    logic                fft_we_q,     fft_we_d;
    logic [ADDR_W-1:0]   fft_base_q,   fft_base_d;

    logic                mem_en_q,     mem_en_d;
    logic                mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;

    logic                pipe_rvalid_q, pipe_rvalid_d;
    logic [DATA_W-1:0]   pipe_rdata_q,  pipe_rdata_d;

    logic                fft_gnt_q,    fft_gnt_d;
    logic                fft_beat_q,   fft_beat_d;
    logic                fft_rvalid_q, fft_rvalid_d;
    logic                fft_done_q,   fft_done_d;

    logic                preq;
    logic                pipe_acc;
    logic                fft_acc;

    // A flushed request is treated as absent: it neither stalls nor wins arbitration.
    assign preq = (bus.pipe_ld | bus.pipe_st) & ~bus.pipe_flush;

    // The pipeline loses a tie only right after it owned the memory, so a pending
    // pipeline access always slips in between two consecutive bursts.
    assign pipe_acc = (state_q == IDLE) & preq & (~bus.fft_req | (last_owner_q == OWNER_FFT));
    assign fft_acc  = (state_q == IDLE) & ~pipe_acc & bus.fft_req;

    assign bus.pipe_stall  = preq & ~pipe_acc;
    assign bus.pipe_rvalid = pipe_rvalid_q;
    assign bus.pipe_rdata  = pipe_rdata_q;

    assign bus.fft_gnt     = fft_gnt_q;
    assign bus.fft_beat    = fft_beat_q;
    assign bus.fft_rvalid  = fft_rvalid_q;
    assign bus.fft_done    = fft_done_q;
    // The macro output is already a register; it is forwarded in the cycle after
    // each read beat and forced to zero otherwise.
    assign bus.fft_rdata   = fft_rvalid_q ? bus.mem_rdata : '0;

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    // Burst write data is presented by the FFT engine in its own beat cycle, so it
    // bypasses the data register; pipeline store data comes from the register.
    assign bus.mem_wdata   = ((state_q == F_BURST) && fft_we_q) ? bus.fft_wdata : mem_wdata_q;

    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        beat_d        = beat_q;
        flushed_d     = flushed_q;
        fft_we_d      = fft_we_q;
        fft_base_d    = fft_base_q;

        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;

        pipe_rvalid_d = 1'b0;
        pipe_rdata_d  = pipe_rdata_q;

        fft_gnt_d     = 1'b0;
        fft_beat_d    = 1'b0;
        fft_rvalid_d  = 1'b0;
        fft_done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                if (pipe_acc) begin
                    last_owner_d = OWNER_PIPE;
                    mem_en_d     = 1'b1;
                    mem_addr_d   = bus.pipe_addr;
                    if (bus.pipe_st) begin
                        // Stores stay in IDLE so a new request can be taken next edge.
                        mem_we_d    = 1'b1;
                        mem_wdata_d = bus.pipe_wdata;
                    end else begin
                        state_d = P_RD;
                    end
                end else if (fft_acc) begin
                    state_d    = F_BURST;
                    fft_we_d   = bus.fft_we;
                    fft_base_d = bus.fft_base;
                    beat_d     = '0;
                    fft_gnt_d  = 1'b1;
                    fft_beat_d = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_we_d   = bus.fft_we;
                    mem_addr_d = bus.fft_base;
                end
            end

            P_RD: begin
                state_d   = P_RESP;
                flushed_d = flushed_q | bus.pipe_flush;
            end

            P_RESP: begin
                // The read has already been issued; a flush only suppresses the response.
                state_d   = IDLE;
                flushed_d = 1'b0;
                if (!(flushed_q | bus.pipe_flush)) begin
                    pipe_rvalid_d = 1'b1;
                    pipe_rdata_d  = bus.mem_rdata;
                end
            end

            F_BURST: begin
                fft_rvalid_d = ~fft_we_q;
                if (beat_q == BEAT_W'(FFT_LEN - 1)) begin
                    state_d    = F_DRAIN;
                    fft_done_d = 1'b1;
                end else begin
                    beat_d     = beat_q + BEAT_W'(1);
                    fft_beat_d = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_we_d   = fft_we_q;
                    // Address arithmetic is ADDR_W wide, so bursts wrap modulo memory size.
                    mem_addr_d = fft_base_q + ADDR_W'(beat_d);
                end
            end

            F_DRAIN: begin
                state_d      = IDLE;
                last_owner_d = OWNER_FFT;
                beat_d       = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_owner_q  <= OWNER_FFT;
            beat_q        <= '0;
            flushed_q     <= 1'b0;
            fft_we_q      <= 1'b0;
            fft_base_q    <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            pipe_rvalid_q <= 1'b0;
            pipe_rdata_q  <= '0;
            fft_gnt_q     <= 1'b0;
            fft_beat_q    <= 1'b0;
            fft_rvalid_q  <= 1'b0;
            fft_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            beat_q        <= beat_d;
            flushed_q     <= flushed_d;
            fft_we_q      <= fft_we_d;
            fft_base_q    <= fft_base_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            pipe_rvalid_q <= pipe_rvalid_d;
            pipe_rdata_q  <= pipe_rdata_d;
            fft_gnt_q     <= fft_gnt_d;
            fft_beat_q    <= fft_beat_d;
            fft_rvalid_q  <= fft_rvalid_d;
            fft_done_q    <= fft_done_d;
        end
    end

endmodule
